// File: rtl/booth_pkg.sv
// Shared definitions for the radix-8 Booth multiplier control and datapath:
// controller state encoding, multiple-select codes, width/step derivation
// and the Booth digit table.
package booth_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Multiple of the multiplicand selected for an add/subtract
  typedef enum logic [1:0] {
    MSEL_M1 = 2'd0,
    MSEL_M2 = 2'd1,
    MSEL_M3 = 2'd2,
    MSEL_M4 = 2'd3
  } msel_t;

  localparam int WIDTH_DEFAULT = 8;

  // Booth digits needed to cover a WIDTH-bit operand plus its sign:
  // ceil((width + 1) / 3)
  function automatic int booth_steps(input int width);
    return (width + 3) / 3;
  endfunction

  // Radix-8 digit for each 4-bit window, as 4-bit two's complement.
  // Entry n sits in nibble n (entry 15 is the leftmost nibble).
  localparam logic [15:0][3:0] DIGIT_TABLE = 64'h0FFE_EDDC_4332_2110;

endpackage

// File: rtl/booth_r8_encoder.sv
// Radix-8 Booth window encoder: turns a 4-bit overlapping window of the
// multiplier into add/subtract intent and the multiple select code.
module booth_r8_encoder
  import booth_pkg::*;
(
  input  logic [3:0] window,
  output logic       nonzero,
  output logic       negative,
  output logic [1:0] msel
);

  logic [3:0] digit;

  // Table lookup, then split the signed digit into sign and magnitude code
  always_comb begin
    digit    = DIGIT_TABLE[window];
    nonzero  = (digit != 4'd0);
    negative = digit[3];
    case (digit)
      4'h1, 4'hF: msel = MSEL_M1;
      4'h2, 4'hE: msel = MSEL_M2;
      4'h3, 4'hD: msel = MSEL_M3;
      4'h4, 4'hC: msel = MSEL_M4;
      default:    msel = MSEL_M1;
    endcase
  end

endmodule

// File: rtl/booth_r8_ctrl.sv
// Radix-8 Booth multiplier controller. Captures the multiplier on Start,
// walks its overlapping 4-bit windows and issues Load / Add / Addc / Shift
// commands to the datapath, finishing with a one-cycle Done pulse.
// All outputs are registered and decoded from the state being entered.
module booth_r8_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Mplier,
  output logic             Load,
  output logic             Add,
  output logic             Addc,
  output logic [1:0]       MSel,
  output logic             Shift,
  output logic             Busy,
  output logic             Done
);

  localparam int STEPS  = booth_steps(WIDTH);
  localparam int SR_W   = 3 * STEPS + 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t            state_reg;
  logic [SR_W-1:0]   sr_reg;
  logic [STEP_W-1:0] step_reg;

  logic [3:0] window;
  logic       enc_nonzero;
  logic       enc_negative;
  logic [1:0] enc_msel;

  // Window seen by the EVAL cycle about to be entered: leaving SHIFT the
  // register is shifting by 3 on the same edge, so look 3 bits higher.
  assign window = (state_reg == ST_SHIFT) ? sr_reg[6:3] : sr_reg[3:0];

  booth_r8_encoder u_encoder (
    .window   (window),
    .nonzero  (enc_nonzero),
    .negative (enc_negative),
    .msel     (enc_msel)
  );

  // Sequencer: state, shadow register, step count and registered commands
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      sr_reg    <= '0;
      step_reg  <= '0;
      Load      <= 1'b0;
      Add       <= 1'b0;
      Addc      <= 1'b0;
      MSel      <= MSEL_M1;
      Shift     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Load  <= 1'b0;
      Add   <= 1'b0;
      Addc  <= 1'b0;
      MSel  <= MSEL_M1;
      Shift <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            // Low bit is the implicit b(-1) = 0
            sr_reg    <= {{(SR_W - 1 - WIDTH){Mplier[WIDTH-1]}}, Mplier, 1'b0};
            state_reg <= ST_LOAD;
            Load      <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          step_reg  <= '0;
          state_reg <= ST_EVAL;
          Busy      <= 1'b1;
          Add       <= enc_nonzero & ~enc_negative;
          Addc      <= enc_nonzero & enc_negative;
          MSel      <= enc_msel;
        end
        ST_EVAL: begin
          state_reg <= ST_SHIFT;
          Shift     <= 1'b1;
          Busy      <= 1'b1;
        end
        ST_SHIFT: begin
          sr_reg   <= {{3{sr_reg[SR_W-1]}}, sr_reg[SR_W-1:3]};
          step_reg <= step_reg + 1'b1;
          Busy     <= 1'b1;
          if (step_reg == LAST_STEP) begin
            state_reg <= ST_DONE;
            Done      <= 1'b1;
          end else begin
            state_reg <= ST_EVAL;
            Add       <= enc_nonzero & ~enc_negative;
            Addc      <= enc_nonzero & enc_negative;
            MSel      <= enc_msel;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r8_ctrl.sv
// Bench for booth_r8_ctrl: a behavioural radix-8 datapath follows the
// controller's commands; expected command words and products are queued
// when Start is driven and compared when the controller reaches them.
module tb_booth_r8_ctrl;

  localparam int WIDTH = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Mplier = 8'h00;
  logic       Load, Add, Addc, Shift, Busy, Done;
  logic [1:0] MSel;
  logic [7:0] outs;

  booth_r8_ctrl #(.WIDTH(WIDTH)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Mplier (Mplier),
    .Load   (Load),
    .Add    (Add),
    .Addc   (Addc),
    .MSel   (MSel),
    .Shift  (Shift),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  assign outs = {Load, Add, Addc, MSel, Shift, Busy, Done};

  int checks = 0;
  int errors = 0;

  logic [3:0]  cmd_q[$];
  logic [15:0] prod_q[$];
  logic [3:0]  mon_cmd;
  logic [15:0] mon_prod;
  logic [7:0]  mp_lat = 8'h00;
  logic [7:0]  mc_lat = 8'h00;
  int          phase = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected {Add, Addc, MSel} for Booth digit i, from the digit formula
  function automatic logic [3:0] exp_cmd(input logic [7:0] mp, input int i);
    logic [9:0] e;
    int d, mag;
    logic [1:0] ms;
    e   = {mp[7], mp, 1'b0};
    d   = -4 * int'(e[3*i+3]) + 2 * int'(e[3*i+2]) + int'(e[3*i+1]) + int'(e[3*i]);
    mag = (d < 0) ? -d : d;
    ms  = (mag == 0) ? 2'd0 : 2'(mag - 1);
    return {(d > 0), (d < 0), ms};
  endfunction

  task automatic push_op(input logic [7:0] mp, input logic [7:0] mc);
    for (int i = 0; i < 3; i++) cmd_q.push_back(exp_cmd(mp, i));
    prod_q.push_back(16'($signed(mp) * $signed(mc)));
  endtask

  // Drive a start for one cycle; returns during the Load cycle
  task automatic start_op(input logic [7:0] mp, input logic [7:0] mc);
    Mplier = mp;
    mp_lat = mp;
    mc_lat = mc;
    push_op(mp, mc);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  // Bounded wait for Done; returns in the cycle after Done
  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    @(posedge Clock); #1;
  endtask

  // Behavioural datapath: A accumulates multiples, {A,Q} shifts right by 3
  logic signed [15:0] dp_a, dp_m;
  logic [8:0]         dp_q;
  logic [24:0]        dp_aq;
  assign dp_aq = {dp_a, dp_q};

  function automatic logic signed [15:0] multiple(input logic [1:0] s, input logic signed [15:0] m);
    case (s)
      2'd0:    return m;
      2'd1:    return m <<< 1;
      2'd2:    return m + (m <<< 1);
      default: return m <<< 2;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      dp_a <= '0;
      dp_q <= '0;
      dp_m <= '0;
    end else if (Load) begin
      dp_a <= '0;
      dp_q <= {mp_lat[7], mp_lat};
      dp_m <= {{8{mc_lat[7]}}, mc_lat};
    end else if (Add) begin
      dp_a <= dp_a + multiple(MSel, dp_m);
    end else if (Addc) begin
      dp_a <= dp_a - multiple(MSel, dp_m);
    end else if (Shift) begin
      {dp_a, dp_q} <= 25'($signed(dp_aq) >>> 3);
    end
  end

  // Cycle monitor: exclusivity every cycle, then the expected command per phase
  always @(negedge Clock) begin
    if (Reset) begin
      cmd_q.delete();
      prod_q.delete();
      phase = 0;
    end else begin
      chk("exclusive", {Add & Addc, Shift & (Load | Add | Addc), Load & (Add | Addc)}, 0);
      if (phase == 0) begin
        if (Load) begin
          chk("load_expected", 32'(prod_q.size() != 0), 1);
          chk("load_cycle", outs, 8'b1000_0010);
          phase = 1;
        end else begin
          chk("idle_cycle", outs, 8'h00);
        end
      end else if (phase == 1 || phase == 3 || phase == 5) begin
        chk("cmd_avail", 32'(cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) begin
          mon_cmd = cmd_q.pop_front();
          chk($sformatf("eval_step%0d", phase / 2), outs, {1'b0, mon_cmd, 3'b010});
        end
        phase++;
      end else if (phase == 2 || phase == 4 || phase == 6) begin
        chk($sformatf("shift_step%0d", phase / 2 - 1), outs, 8'b0000_0110);
        phase++;
      end else begin
        chk("done_cycle", outs, 8'b0000_0011);
        chk("prod_avail", 32'(prod_q.size() != 0), 1);
        if (prod_q.size() != 0) begin
          mon_prod = prod_q.pop_front();
          chk("product", dp_aq[15:0], mon_prod);
        end
        phase = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] corners [5];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_state", outs, 8'h00);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Directed operand patterns
    start_op(8'h00, 8'h05); wait_done("zero");
    start_op(8'h07, 8'h05); wait_done("mp07");
    start_op(8'h80, 8'h03); wait_done("mp80");
    start_op(8'h1B, 8'h09); wait_done("mp1B");
    start_op(8'h3C, 8'hF1); wait_done("mp3C");

    // Mplier changing after capture must not disturb the run
    start_op(8'h5A, 8'hC3);
    Mplier = 8'hA5;
    wait_done("mplier_change");

    // Start during a running multiply is ignored
    start_op(8'h2D, 8'h11);
    repeat (2) @(posedge Clock);
    #1;
    Start  = 1'b1;
    Mplier = 8'hFF;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done("start_busy");

    // Reset mid-operation abandons the sequence
    start_op(8'h6B, 8'h77);
    repeat (4) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("mid_reset_idle", outs, 8'h00);
    start_op(8'h13, 8'h9C); wait_done("after_reset");

    // Start held high: two multiplies separated by one idle cycle
    Mplier = 8'hB7;
    mp_lat = 8'hB7;
    mc_lat = 8'h29;
    push_op(8'hB7, 8'h29);
    push_op(8'hB7, 8'h29);
    Start = 1'b1;
    wait_done("held1");
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done("held2");

    // Operand corners
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        start_op(corners[i], corners[j]);
        wait_done("corner");
      end
    end

    // Random operand sweep
    for (int k = 0; k < 300; k++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done("random");
    end

    @(posedge Clock); #1;
    chk("queues_empty", 32'(prod_q.size() + cmd_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
